// File: rtl/psram_byte_port.sv
// Byte-wide client port for one channel of the Gowin PSRAM IP (32-bit word interface).
// A one-entry request slot lets the client post a request while the previous one is still running.
module psram_byte_port #(
    parameter int ADDR_W    = 22,
    parameter int IP_ADDR_W = 21,
    parameter int WAIT_CNT  = 14,
    parameter int RD_TMO    = 63
) (
    input  logic                 clk,
    input  logic                 n_reset,
    // Client side: a request is taken on a rising edge where busy=0 and rd|wr=1 (wr wins).
    // A request seen while busy=1 is ignored, and the client holds it until busy drops.
    input  logic                 rd,
    input  logic                 wr,
    input  logic [ADDR_W-1:0]    address,
    input  logic [7:0]           wdata,
    output logic                 busy,
    output logic [7:0]           rdata,
    output logic                 rdata_en,
    output logic                 rd_err,
    // IP side
    input  logic                 ip_init_calib,
    output logic                 ip_cmd,
    output logic                 ip_cmd_en,
    output logic [IP_ADDR_W-1:0] ip_addr,
    output logic [31:0]          ip_wr_data,
    output logic [3:0]           ip_data_mask,
    input  logic [31:0]          ip_rd_data,
    input  logic                 ip_rd_valid,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                 state_q, state_d;
    logic                   slot_valid_q, slot_valid_d;
    logic                   slot_wr_q, slot_wr_d;
    logic [ADDR_W-1:0]      slot_addr_q, slot_addr_d;
    logic [7:0]             slot_wdata_q, slot_wdata_d;
    logic                   eng_wr_q, eng_wr_d;
    logic [1:0]             lane_q, lane_d;
    logic                   cap_q, cap_d;
    logic [7:0]             wait_cnt_q, wait_cnt_d;
    logic [7:0]             tmo_cnt_q, tmo_cnt_d;
    logic [7:0]             rdata_q, rdata_d;
    logic                   rdata_en_q, rdata_en_d;
    logic                   rd_err_q, rd_err_d;
    logic                   ip_cmd_q, ip_cmd_d;
    logic                   ip_cmd_en_q, ip_cmd_en_d;
    logic [IP_ADDR_W-1:0]   ip_addr_q, ip_addr_d;
    logic [31:0]            ip_wr_data_q, ip_wr_data_d;
    logic [3:0]             ip_mask_q, ip_mask_d;
    logic                   accept;
    logic                   wait_done;
    logic                   rd_seen;

    assign busy   = (state_q == S_INIT) || slot_valid_q;
    assign accept = !busy && (rd || wr);
    // The counter starts at issue; the IDLE hop ahead of the next issue uses up its final cycle.
    assign wait_done = (wait_cnt_q <= 8'd1);
    assign rd_seen   = cap_q || ip_rd_valid;

    always_comb begin
        state_d      = state_q;
        slot_valid_d = slot_valid_q;
        slot_wr_d    = slot_wr_q;
        slot_addr_d  = slot_addr_q;
        slot_wdata_d = slot_wdata_q;
        eng_wr_d     = eng_wr_q;
        lane_d       = lane_q;
        cap_d        = cap_q;
        wait_cnt_d   = (wait_cnt_q != 8'd0) ? wait_cnt_q - 8'd1 : 8'd0;
        tmo_cnt_d    = (tmo_cnt_q != 8'd0) ? tmo_cnt_q - 8'd1 : 8'd0;
        rdata_d      = rdata_q;
        rdata_en_d   = 1'b0;
        rd_err_d     = 1'b0;
        ip_cmd_d     = ip_cmd_q;
        ip_cmd_en_d  = 1'b0;
        ip_addr_d    = ip_addr_q;
        ip_wr_data_d = ip_wr_data_q;
        ip_mask_d    = ip_mask_q;

        if (accept) begin
            slot_valid_d = 1'b1;
            slot_wr_d    = wr;
            slot_addr_d  = address;
            slot_wdata_d = wdata;
        end

        case (state_q)
            S_INIT: begin
                if (ip_init_calib) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (slot_valid_q) begin
                    state_d      = S_ISSUE;
                    slot_valid_d = 1'b0;
                    eng_wr_d     = slot_wr_q;
                    lane_d       = slot_addr_q[1:0];
                    cap_d        = 1'b0;
                    ip_cmd_d     = slot_wr_q;
                    ip_cmd_en_d  = 1'b1;
                    ip_addr_d    = IP_ADDR_W'(slot_addr_q[ADDR_W-1:2]);
                    ip_wr_data_d = {4{slot_wdata_q}};
                    ip_mask_d    = slot_wr_q ? ~(4'b0001 << slot_addr_q[1:0]) : 4'b0000;
                    wait_cnt_d   = 8'(WAIT_CNT);
                    tmo_cnt_d    = 8'(RD_TMO);
                end
            end
            S_ISSUE: begin
                state_d   = S_WAIT;
                ip_mask_d = 4'hF;
            end
            S_WAIT: begin
                if (eng_wr_q) begin
                    if (wait_done) state_d = S_IDLE;
                end else begin
                    if (!cap_q && ip_rd_valid) begin
                        cap_d      = 1'b1;
                        rdata_d    = ip_rd_data[{lane_q, 3'b000} +: 8];
                        rdata_en_d = 1'b1;
                    end
                    if (wait_done && rd_seen) begin
                        state_d = S_IDLE;
                    end else if (!rd_seen && tmo_cnt_q == 8'd0) begin
                        rdata_d    = 8'hFF;
                        rdata_en_d = 1'b1;
                        rd_err_d   = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase

        // Losing calibration abandons everything, including a read still in flight.
        if (!ip_init_calib) begin
            state_d      = S_INIT;
            slot_valid_d = 1'b0;
            slot_wr_d    = 1'b0;
            slot_addr_d  = '0;
            slot_wdata_d = 8'h00;
            eng_wr_d     = 1'b0;
            lane_d       = 2'd0;
            cap_d        = 1'b0;
            wait_cnt_d   = 8'd0;
            tmo_cnt_d    = 8'd0;
            rdata_d      = 8'h00;
            rdata_en_d   = 1'b0;
            rd_err_d     = 1'b0;
            ip_cmd_d     = 1'b0;
            ip_cmd_en_d  = 1'b0;
            ip_addr_d    = '0;
            ip_wr_data_d = 32'h0;
            ip_mask_d    = 4'hF;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= S_INIT;
            slot_valid_q <= 1'b0;
            slot_wr_q    <= 1'b0;
            slot_addr_q  <= '0;
            slot_wdata_q <= 8'h00;
            eng_wr_q     <= 1'b0;
            lane_q       <= 2'd0;
            cap_q        <= 1'b0;
            wait_cnt_q   <= 8'd0;
            tmo_cnt_q    <= 8'd0;
            rdata_q      <= 8'h00;
            rdata_en_q   <= 1'b0;
            rd_err_q     <= 1'b0;
            ip_cmd_q     <= 1'b0;
            ip_cmd_en_q  <= 1'b0;
            ip_addr_q    <= '0;
            ip_wr_data_q <= 32'h0;
            ip_mask_q    <= 4'hF;
        end else begin
            state_q      <= state_d;
            slot_valid_q <= slot_valid_d;
            slot_wr_q    <= slot_wr_d;
            slot_addr_q  <= slot_addr_d;
            slot_wdata_q <= slot_wdata_d;
            eng_wr_q     <= eng_wr_d;
            lane_q       <= lane_d;
            cap_q        <= cap_d;
            wait_cnt_q   <= wait_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            rdata_q      <= rdata_d;
            rdata_en_q   <= rdata_en_d;
            rd_err_q     <= rd_err_d;
            ip_cmd_q     <= ip_cmd_d;
            ip_cmd_en_q  <= ip_cmd_en_d;
            ip_addr_q    <= ip_addr_d;
            ip_wr_data_q <= ip_wr_data_d;
            ip_mask_q    <= ip_mask_d;
        end
    end

    assign rdata        = rdata_q;
    assign rdata_en     = rdata_en_q;
    assign rd_err       = rd_err_q;
    assign ip_cmd       = ip_cmd_q;
    assign ip_cmd_en    = ip_cmd_en_q;
    assign ip_addr      = ip_addr_q;
    assign ip_wr_data   = ip_wr_data_q;
    assign ip_data_mask = ip_mask_q;
    assign dbg_state    = state_q;

endmodule
